spi_burst_sequencer: RTL and testbench
======================================

// Module: spi_burst_sequencer
// PURPOSE
//  Upstream feeder for spi_controller_top: buffers host TX bytes in a FIFO, issues them one at a
//  time over the controller's request_tx/data/ready/rx_valid interface, and stores each received
//  byte in an RX FIFO. Turns single-byte SPI transactions into host-driven bursts.
// PARAMETERS
//  DEPTH      16    entries per FIFO (power of two, >=2)
//  ADDR_W     4     log2(DEPTH)
//  TIMEOUT    1023  max cycles in REQ or WAIT_RX before abort
// PORTS
//  i_clk             in   1       system clock
//  i_rst             in   1       asynchronous, active-high reset
//  i_tx_push         in   1       write i_tx_data into TX FIFO
//  i_tx_data         in   8       byte to send
//  o_tx_full         out  1       TX FIFO full
//  o_tx_count        out  ADDR_W+1 TX FIFO occupancy
//  i_rx_pop          in   1       pop RX FIFO head
//  o_rx_data         out  8       RX FIFO head (first-word-fall-through)
//  o_rx_empty        out  1       RX FIFO empty
//  o_rx_count        out  ADDR_W+1 RX FIFO occupancy
//  i_start           in   1       begin burst: drain TX FIFO
//  i_clr_err         in   1       clear sticky error flags
//  o_busy            out  1       FSM not IDLE
//  o_done            out  1       1-cycle pulse at burst end (normal or abort)
//  o_err_timeout     out  1       sticky: controller handshake timed out
//  o_rx_overflow     out  1       sticky: RX byte dropped, RX FIFO full
//  o_spi_request_tx  out  1       to controller i_request_tx
//  o_spi_data        out  8       to controller i_data
//  i_spi_ready       in   1       from controller o_ready
//  i_spi_rx_valid    in   1       from controller o_rx_valid
//  i_spi_data        in   8       from controller o_data
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE, FIFOs empty, all outputs 0 except o_tx_full=0, o_rx_empty=1.
//  FSM states: IDLE, LOAD, REQ, WAIT_RX, CAPTURE, DONE.
//  - IDLE: i_start=1 -> LOAD if TX non-empty, else DONE. i_start ignored when busy.
//  - LOAD: pop TX head into o_spi_data register (held stable until next LOAD) -> REQ.
//  - REQ: o_spi_request_tx=1; stays until i_spi_ready=0 (controller accepted; its request input
//    is 2-flop synchronised so acceptance takes >=3 cycles) -> WAIT_RX, request drops same edge.
//  - WAIT_RX: on i_spi_rx_valid=1 -> CAPTURE.
//  - CAPTURE: controller's o_data is registered on rx_valid, so sample i_spi_data here (one cycle
//    after rx_valid); push to RX FIFO; if RX full, drop byte, set o_rx_overflow.
//    Wait for i_spi_ready=1, then -> LOAD if TX non-empty, else DONE.
//  - DONE: o_done=1 for one cycle -> IDLE.
//  Timeout: 10-bit cycle counter, cleared on entry to REQ and WAIT_RX; reaching TIMEOUT drops
//    request, sets o_err_timeout, -> DONE. Remaining TX bytes are kept, not flushed.
//  FIFOs: push when full ignored (TX: no flag; host checks o_tx_full); pop when empty ignored;
//    simultaneous push+pop at full or empty are both legal; count unchanged (empty: data passes).
//    Pointers ADDR_W bits, wrap modulo DEPTH; count range 0..DEPTH.
//  Host i_tx_push during a burst is allowed; pushed bytes join the current burst.
//  i_clr_err clears sticky flags; if it coincides with a new error event, the error wins.
// STRUCTURE
//  spi_defs.vh: state localparams (one-hot, 6 bits), TIMEOUT width constant.
//  Sub-module: sync_fifo (DEPTH/ADDR_W params, FWFT, count, full/empty); instantiated for TX and RX.
//  Top: FSM, o_spi_data register, timeout counter, sticky flags.
// TESTING
//  1. Push 0xA5,0x3C; start; SPI model echoes ~data -> RX holds 0x5A,0xC3; one o_done; busy drops.
//  2. Start with TX empty -> o_done 2 cycles later; o_spi_request_tx never asserted.
//  3. Model holds ready=1 forever -> timeout after 1023 cycles; o_err_timeout=1; byte stays consumed;
//     i_clr_err clears the flag.
//  4. Preload RX with 16 bytes; burst 2 bytes -> o_rx_overflow=1, rx_count stays 16, burst completes.
//  5. Push 17 bytes -> o_tx_full after 16th, tx_count=16, 17th dropped; push+pop at full keeps 16.
//  6. Assert i_rst while in WAIT_RX -> request low, FIFOs empty, busy=0 immediately, no o_done pulse.

Source files
------------

// File: rtl/spi_burst_sequencer_pkg.sv
// Shared constants and state encoding for the SPI burst sequencer.
// States are one-hot so that busy/request/done decode straight from a single flop bit.
package spi_burst_sequencer_pkg;

    localparam int DEF_DEPTH   = 16;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_TIMEOUT = 1023;
    localparam int TMR_W       = 10;

    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_LOAD    = 6'b000010,
        ST_REQ     = 6'b000100,
        ST_WAIT_RX = 6'b001000,
        ST_CAPTURE = 6'b010000,
        ST_DONE    = 6'b100000
    } state_e;

endpackage

// File: rtl/spi_burst_sequencer_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Push+pop together is always honoured at full or empty; when empty the pushed word is shown on o_data.
module spi_burst_sequencer_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [WIDTH-1:0]  i_data,
    input  logic              i_pop,
    output logic [WIDTH-1:0]  o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count
);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_full    = (r_count == (ADDR_W+1)'(DEPTH));
    assign o_empty   = (r_count == (ADDR_W+1)'(0));
    assign o_count   = r_count;
    assign w_push_ok = i_push && (!o_full || i_pop);
    assign w_pop_ok  = i_pop && (!o_empty || i_push);

    // Storage array, written only on an accepted push.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= {ADDR_W{1'b0}};
            r_rd_ptr <= {ADDR_W{1'b0}};
            r_count  <= {(ADDR_W+1){1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head word; bypasses the incoming word while empty.
    always_comb begin
        o_data = {WIDTH{1'b0}};
        if (o_empty) begin
            o_data = i_push ? i_data : {WIDTH{1'b0}};
        end else begin
            o_data = r_mem[r_rd_ptr];
        end
    end

endmodule

// File: rtl/spi_burst_sequencer.sv
// Drains a TX byte FIFO one byte at a time through the SPI controller handshake
// and collects each returned byte into an RX FIFO, with timeout and overflow reporting.
module spi_burst_sequencer
    import spi_burst_sequencer_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tx_push,
    input  logic [7:0]        i_tx_data,
    output logic              o_tx_full,
    output logic [ADDR_W:0]   o_tx_count,
    input  logic              i_rx_pop,
    output logic [7:0]        o_rx_data,
    output logic              o_rx_empty,
    output logic [ADDR_W:0]   o_rx_count,
    input  logic              i_start,
    input  logic              i_clr_err,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err_timeout,
    output logic              o_rx_overflow,
    output logic              o_spi_request_tx,
    output logic [7:0]        o_spi_data,
    input  logic              i_spi_ready,
    input  logic              i_spi_rx_valid,
    input  logic [7:0]        i_spi_data
);

    state_e            r_state;
    state_e            w_next;
    logic [7:0]        r_spi_data;
    logic [TMR_W-1:0]  r_timer;
    logic              r_cap_done;
    logic              r_done;
    logic              r_err_timeout;
    logic              r_rx_overflow;
    logic              w_tx_pop;
    logic              w_tx_empty;
    logic [7:0]        w_tx_head;
    logic              w_rx_push;
    logic              w_rx_full;
    logic              w_capture_first;
    logic              w_timeout_hit;
    logic              w_set_timeout;
    logic              w_set_overflow;

    spi_burst_sequencer_sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WIDTH(8)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_tx_push),
        .i_data  (i_tx_data),
        .i_pop   (w_tx_pop),
        .o_data  (w_tx_head),
        .o_full  (o_tx_full),
        .o_empty (w_tx_empty),
        .o_count (o_tx_count)
    );

    spi_burst_sequencer_sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WIDTH(8)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_rx_push),
        .i_data  (i_spi_data),
        .i_pop   (i_rx_pop),
        .o_data  (o_rx_data),
        .o_full  (w_rx_full),
        .o_empty (o_rx_empty),
        .o_count (o_rx_count)
    );

    // Controller data is registered on rx_valid, so the byte is taken on the first CAPTURE cycle only.
    assign w_capture_first = (r_state == ST_CAPTURE) && !r_cap_done;
    assign w_rx_push       = w_capture_first && !w_rx_full;
    assign w_set_overflow  = w_capture_first && w_rx_full;
    assign w_timeout_hit   = (r_timer == TMR_W'(TIMEOUT));

    // Next-state and handshake decode.
    always_comb begin
        w_next        = r_state;
        w_tx_pop      = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next = w_tx_empty ? ST_DONE : ST_LOAD;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_tx_pop = 1'b1;
                w_next   = ST_REQ;
            end
            ST_REQ: begin
                if (w_timeout_hit) begin
                    w_set_timeout = 1'b1;
                    w_next        = ST_DONE;
                end else if (!i_spi_ready) begin
                    w_next = ST_WAIT_RX;
                end else begin
                    w_next = ST_REQ;
                end
            end
            ST_WAIT_RX: begin
                if (w_timeout_hit) begin
                    w_set_timeout = 1'b1;
                    w_next        = ST_DONE;
                end else if (i_spi_rx_valid) begin
                    w_next = ST_CAPTURE;
                end else begin
                    w_next = ST_WAIT_RX;
                end
            end
            ST_CAPTURE: begin
                if (i_spi_ready) begin
                    w_next = w_tx_empty ? ST_DONE : ST_LOAD;
                end else begin
                    w_next = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outgoing byte, capture flag, done pulse and handshake timer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_spi_data <= 8'h00;
            r_cap_done <= 1'b0;
            r_done     <= 1'b0;
            r_timer    <= {TMR_W{1'b0}};
        end else begin
            if (w_tx_pop) begin
                r_spi_data <= w_tx_head;
            end
            r_cap_done <= (r_state == ST_CAPTURE) && (w_next == ST_CAPTURE);
            r_done     <= (r_state == ST_DONE);
            if ((w_next != r_state) || !(r_state inside {ST_REQ, ST_WAIT_RX})) begin
                r_timer <= {TMR_W{1'b0}};
            end else begin
                r_timer <= r_timer + TMR_W'(1);
            end
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_timeout <= 1'b0;
            r_rx_overflow <= 1'b0;
        end else begin
            if (w_set_timeout) begin
                r_err_timeout <= 1'b1;
            end else if (i_clr_err) begin
                r_err_timeout <= 1'b0;
            end
            if (w_set_overflow) begin
                r_rx_overflow <= 1'b1;
            end else if (i_clr_err) begin
                r_rx_overflow <= 1'b0;
            end
        end
    end

    assign o_busy           = (r_state != ST_IDLE);
    assign o_spi_request_tx = (r_state == ST_REQ);
    assign o_done           = r_done;
    assign o_err_timeout    = r_err_timeout;
    assign o_rx_overflow    = r_rx_overflow;
    assign o_spi_data       = r_spi_data;

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Directed bench for spi_burst_sequencer with a small behavioural SPI controller model
// that echoes the inverted byte back after a synchronised request handshake.
module tb_spi_burst_sequencer;

    logic       clk;
    logic       rst;
    logic       tx_push;
    logic [7:0] tx_data;
    logic       tx_full;
    logic [4:0] tx_count;
    logic       rx_pop;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic [4:0] rx_count;
    logic       start;
    logic       clr_err;
    logic       busy;
    logic       done;
    logic       err_timeout;
    logic       rx_overflow;
    logic       spi_req;
    logic [7:0] spi_wdata;
    logic       spi_ready;
    logic       spi_rx_valid;
    logic [7:0] spi_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int req_cnt  = 0;

    logic       m_stuck;
    int         m_cnt;
    int         m_phase;
    logic [7:0] m_byte;

    spi_burst_sequencer dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_tx_push        (tx_push),
        .i_tx_data        (tx_data),
        .o_tx_full        (tx_full),
        .o_tx_count       (tx_count),
        .i_rx_pop         (rx_pop),
        .o_rx_data        (rx_data),
        .o_rx_empty       (rx_empty),
        .o_rx_count       (rx_count),
        .i_start          (start),
        .i_clr_err        (clr_err),
        .o_busy           (busy),
        .o_done           (done),
        .o_err_timeout    (err_timeout),
        .o_rx_overflow    (rx_overflow),
        .o_spi_request_tx (spi_req),
        .o_spi_data       (spi_wdata),
        .i_spi_ready      (spi_ready),
        .i_spi_rx_valid   (spi_rx_valid),
        .i_spi_data       (spi_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller model: accept after 3 request cycles, rx_valid 3 cycles later, data one cycle after.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_ready    <= 1'b1;
            spi_rx_valid <= 1'b0;
            spi_rdata    <= 8'h00;
            m_cnt        <= 0;
            m_phase      <= 0;
            m_byte       <= 8'h00;
        end else begin
            case (m_phase)
                0: begin
                    if (spi_req && !m_stuck) begin
                        if (m_cnt == 2) begin
                            spi_ready <= 1'b0;
                            m_byte    <= spi_wdata;
                            m_cnt     <= 0;
                            m_phase   <= 1;
                        end else begin
                            m_cnt <= m_cnt + 1;
                        end
                    end else begin
                        m_cnt <= 0;
                    end
                end
                1: begin
                    if (m_cnt == 2) begin
                        spi_rx_valid <= 1'b1;
                        m_cnt        <= 0;
                        m_phase      <= 2;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
                2: begin
                    spi_rx_valid <= 1'b0;
                    spi_rdata    <= ~m_byte;
                    m_phase      <= 3;
                end
                3: begin
                    spi_ready <= 1'b1;
                    m_phase   <= 0;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (done)    done_cnt <= done_cnt + 1;
        if (spi_req) req_cnt  <= req_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        tx_push = 1'b1;
        tx_data = b;
        tick();
        tx_push = 1'b0;
    endtask

    task automatic pop();
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int cyc);
        cyc = 0;
        while (!done && cyc < lim) begin
            tick();
            cyc++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    int cyc;
    int d0;
    int r0;
    int lim;

    initial begin
        rst = 1'b1; tx_push = 1'b0; tx_data = 8'h00; rx_pop = 1'b0;
        start = 1'b0; clr_err = 1'b0; m_stuck = 1'b0;
        tick(); tick(); tick();
        chk("rst_busy",     {31'd0, busy},        32'd0);
        chk("rst_done",     {31'd0, done},        32'd0);
        chk("rst_req",      {31'd0, spi_req},     32'd0);
        chk("rst_tx_full",  {31'd0, tx_full},     32'd0);
        chk("rst_tx_count", {27'd0, tx_count},    32'd0);
        chk("rst_rx_empty", {31'd0, rx_empty},    32'd1);
        chk("rst_rx_count", {27'd0, rx_count},    32'd0);
        chk("rst_errs",     {30'd0, err_timeout, rx_overflow}, 32'd0);
        chk("rst_spi_data", {24'd0, spi_wdata},   32'd0);
        rst = 1'b0;
        tick();

        // Two-byte echo burst
        push(8'hA5);
        push(8'h3C);
        chk("t1_tx_count", {27'd0, tx_count}, 32'd2);
        d0 = done_cnt;
        pulse_start();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_done(200, cyc);
        tick();
        chk("t1_done_once", done_cnt - d0,       32'd1);
        chk("t1_busy_low",  {31'd0, busy},       32'd0);
        chk("t1_rx_count",  {27'd0, rx_count},   32'd2);
        chk("t1_rx0",       {24'd0, rx_data},    32'h5A);
        chk("t1_spi_data",  {24'd0, spi_wdata},  32'h3C);
        pop();
        chk("t1_rx1",       {24'd0, rx_data},    32'hC3);
        pop();
        chk("t1_rx_empty",  {31'd0, rx_empty},   32'd1);
        chk("t1_no_err",    {30'd0, err_timeout, rx_overflow}, 32'd0);

        // Start with TX empty: done two cycles after start, no request
        r0 = req_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_done_early", {31'd0, done}, 32'd0);
        chk("t2_busy",       {31'd0, busy}, 32'd1);
        tick();
        chk("t2_done",       {31'd0, done}, 32'd1);
        tick();
        chk("t2_done_pulse", {31'd0, done}, 32'd0);
        chk("t2_no_req",     req_cnt - r0,  32'd0);

        // Controller never accepts: timeout
        m_stuck = 1'b1;
        push(8'h55);
        pulse_start();
        wait_done(1200, cyc);
        chk("t3_latency_ok", {31'd0, (cyc >= 1023 && cyc <= 1030)}, 32'd1);
        chk("t3_err",        {31'd0, err_timeout}, 32'd1);
        chk("t3_req_low",    {31'd0, spi_req},     32'd0);
        chk("t3_consumed",   {27'd0, tx_count},    32'd0);
        chk("t3_rx_empty",   {31'd0, rx_empty},    32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t3_cleared",    {31'd0, err_timeout}, 32'd0);
        m_stuck = 1'b0;
        tick();

        // TX fill to full, push+pop at full, then 17-byte burst overflowing RX
        for (int i = 0; i < 16; i++) begin
            push(8'h10 + 8'(i));
            if (i == 14) chk("t5_not_full_15", {31'd0, tx_full}, 32'd0);
        end
        chk("t5_full",       {31'd0, tx_full},  32'd1);
        chk("t5_count16",    {27'd0, tx_count}, 32'd16);
        push(8'h20);
        chk("t5_drop17",     {27'd0, tx_count}, 32'd16);
        pulse_start();
        tx_push = 1'b1;
        tx_data = 8'h77;
        tick();
        tx_push = 1'b0;
        chk("t5_pushpop_full", {27'd0, tx_count}, 32'd16);
        chk("t5_first_byte",   {24'd0, spi_wdata}, 32'h10);
        wait_done(600, cyc);
        chk("t4_overflow",  {31'd0, rx_overflow}, 32'd1);
        chk("t4_rx_count",  {27'd0, rx_count},    32'd16);
        chk("t4_tx_empty",  {27'd0, tx_count},    32'd0);
        chk("t4_no_timeout",{31'd0, err_timeout}, 32'd0);
        chk("t4_rx_head",   {24'd0, rx_data},     32'hEF);
        for (int i = 0; i < 15; i++) pop();
        chk("t4_rx_last",   {24'd0, rx_data},     32'hE0);
        pop();
        chk("t4_rx_empty",  {31'd0, rx_empty},    32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t4_ovf_cleared", {31'd0, rx_overflow}, 32'd0);

        // Reset while waiting for rx_valid
        push(8'h99);
        push(8'h44);
        pulse_start();
        lim = 0;
        while (!spi_req && lim < 50) begin tick(); lim++; end
        chk("t6_req_seen", {31'd0, spi_req}, 32'd1);
        lim = 0;
        while (spi_req && lim < 50) begin tick(); lim++; end
        chk("t6_in_wait", {31'd0, busy && !spi_req}, 32'd1);
        d0 = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_req_low",  {31'd0, spi_req},   32'd0);
        chk("t6_busy_low", {31'd0, busy},      32'd0);
        chk("t6_tx_empty", {27'd0, tx_count},  32'd0);
        chk("t6_rx_empty", {31'd0, rx_empty},  32'd1);
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t6_no_done",  done_cnt - d0,      32'd0);
        chk("t6_idle",     {31'd0, busy},      32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
